// File: rtl/lightsaber_length_pkg.sv
// Shared encodings for the lightsaber length controller.
// Command opcodes, channel FSM states and the frac limit.
package lightsaber_length_pkg;

  typedef enum logic [1:0] {
    OP_SET     = 2'b00,
    OP_EXTEND  = 2'b01,
    OP_RETRACT = 2'b10,
    OP_SNAP    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_EXTENDING  = 2'b01,
    ST_RETRACTING = 2'b10
  } state_e;

  localparam int FRAC_LIMIT = 100;

endpackage

// File: rtl/lightsaber_length_chan.sv
// One lightsaber channel: length/target registers and ramp FSM.
// Lengths are {int, frac} pairs, frac counting hundredths 0..99.
module lightsaber_length_chan
  import lightsaber_length_pkg::*;
#(
  parameter int INT_W  = 2,
  parameter int FRAC_W = 7,
  parameter int STEP   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              load,
  input  logic              snap,
  input  logic [INT_W-1:0]  val_int,
  input  logic [FRAC_W-1:0] val_frac,
  output logic [INT_W-1:0]  len_int,
  output logic [FRAC_W-1:0] len_frac,
  output logic              busy,
  output logic              done
);

  localparam int IW = INT_W + 1;
  localparam int FW = FRAC_W + 1;
  localparam logic [FW-1:0] STEP_F = FW'(STEP);
  localparam logic [FW-1:0] LIM_F  = FW'(FRAC_LIMIT);

  logic [INT_W-1:0]  len_int_q, len_int_d;
  logic [FRAC_W-1:0] len_frac_q, len_frac_d;
  logic [INT_W-1:0]  tgt_int_q, tgt_int_d;
  logic [FRAC_W-1:0] tgt_frac_q, tgt_frac_d;
  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [IW-1:0] li, ti, ext_i, ret_i;
  logic [FW-1:0] lf, tf, sum_f, ext_f, ret_f;
  logic          borrow, under, ext_hit, ret_hit;
  logic          lt, gt;

  // Candidate up/down steps and whether each overshoots target
  always_comb begin
    li     = {1'b0, len_int_q};
    ti     = {1'b0, tgt_int_q};
    lf     = {1'b0, len_frac_q};
    tf     = {1'b0, tgt_frac_q};
    sum_f  = lf + STEP_F;
    ext_f  = sum_f;
    ext_i  = li;
    if (sum_f >= LIM_F) begin
      ext_f = sum_f - LIM_F;
      ext_i = li + IW'(1);
    end
    borrow = lf < STEP_F;
    under  = borrow && (len_int_q == '0);
    ret_f  = lf - STEP_F;
    ret_i  = li;
    if (borrow) begin
      ret_f = lf + LIM_F - STEP_F;
      ret_i = li - IW'(1);
    end
    ext_hit = (ext_i > ti) ||
              ((ext_i == ti) && (ext_f >= tf));
    ret_hit = under || (ret_i < ti) ||
              ((ret_i == ti) && (ret_f <= tf));
  end

  // Next length/target; commands take priority over ticks
  always_comb begin
    len_int_d  = len_int_q;
    len_frac_d = len_frac_q;
    tgt_int_d  = tgt_int_q;
    tgt_frac_d = tgt_frac_q;
    done_d     = 1'b0;
    if (load) begin
      tgt_int_d  = val_int;
      tgt_frac_d = val_frac;
      if (snap) begin
        len_int_d  = val_int;
        len_frac_d = val_frac;
      end
    end else if (tick && state_q == ST_EXTENDING) begin
      len_int_d  = ext_hit ? tgt_int_q : ext_i[INT_W-1:0];
      len_frac_d = ext_hit ? tgt_frac_q : ext_f[FRAC_W-1:0];
      done_d     = ext_hit;
    end else if (tick && state_q == ST_RETRACTING) begin
      len_int_d  = ret_hit ? tgt_int_q : ret_i[INT_W-1:0];
      len_frac_d = ret_hit ? tgt_frac_q : ret_f[FRAC_W-1:0];
      done_d     = ret_hit;
    end
    lt = (len_int_d < tgt_int_d) ||
         ((len_int_d == tgt_int_d) && (len_frac_d < tgt_frac_d));
    gt = (len_int_d > tgt_int_d) ||
         ((len_int_d == tgt_int_d) && (len_frac_d > tgt_frac_d));
    state_d = lt ? ST_EXTENDING :
              gt ? ST_RETRACTING : ST_IDLE;
    busy_d  = (state_d != ST_IDLE);
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_int_q  <= '0;
      len_frac_q <= '0;
      tgt_int_q  <= '0;
      tgt_frac_q <= '0;
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      len_int_q  <= len_int_d;
      len_frac_q <= len_frac_d;
      tgt_int_q  <= tgt_int_d;
      tgt_frac_q <= tgt_frac_d;
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign len_int  = len_int_q;
  assign len_frac = len_frac_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: rtl/lightsaber_length_ctrl.sv
// Multi-channel lightsaber length controller top.
// Decodes and range-checks commands, fans out to channels.
module lightsaber_length_ctrl
  import lightsaber_length_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int INT_W    = 2,
  parameter int FRAC_W   = 7,
  parameter int STEP     = 5,
  parameter int MAX_INT  = 3,
  parameter int MAX_FRAC = 0,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [CH_W-1:0]          cmd_ch,
  input  logic [1:0]               cmd_op,
  input  logic [INT_W-1:0]         cmd_int,
  input  logic [FRAC_W-1:0]        cmd_frac,
  output logic                     cmd_err,
  output logic [N_CH*INT_W-1:0]    len_int,
  output logic [N_CH*FRAC_W-1:0]   len_frac,
  output logic [N_CH-1:0]          busy,
  output logic [N_CH-1:0]          done
);

  localparam logic [INT_W-1:0]  MAX_I = INT_W'(MAX_INT);
  localparam logic [FRAC_W-1:0] MAX_F = FRAC_W'(MAX_FRAC);
  localparam logic [FRAC_W-1:0] TOP_F = FRAC_W'(FRAC_LIMIT - 1);

  op_e               op;
  logic              accept, chk, bad, snap;
  logic [INT_W-1:0]  val_int;
  logic [FRAC_W-1:0] val_frac;
  logic              cmd_err_q, cmd_err_d;
  logic [N_CH-1:0]   load;

  assign cmd_ready = rst_n;
  assign op        = op_e'(cmd_op);

  // Decode opcode into a target value and range-check operands
  always_comb begin
    accept   = cmd_valid && cmd_ready;
    val_int  = '0;
    val_frac = '0;
    chk      = 1'b0;
    snap     = 1'b0;
    unique case (1'b1)
      op == OP_SET: begin
        val_int  = cmd_int;
        val_frac = cmd_frac;
        chk      = 1'b1;
      end
      op == OP_EXTEND: begin
        val_int  = MAX_I;
        val_frac = MAX_F;
      end
      op == OP_RETRACT: begin
        val_int  = '0;
        val_frac = '0;
      end
      op == OP_SNAP: begin
        val_int  = cmd_int;
        val_frac = cmd_frac;
        chk      = 1'b1;
        snap     = 1'b1;
      end
    endcase
    bad = chk && ((cmd_frac > TOP_F) ||
                  (cmd_int > MAX_I) ||
                  ((cmd_int == MAX_I) && (cmd_frac > MAX_F)));
    cmd_err_d = accept && bad;
  end

  // Rejection pulse lands one cycle after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmd_err_q <= 1'b0;
    else        cmd_err_q <= cmd_err_d;
  end

  assign cmd_err = cmd_err_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign load[c] = accept && !bad && (cmd_ch == CH_W'(c));

    lightsaber_length_chan #(
      .INT_W  (INT_W),
      .FRAC_W (FRAC_W),
      .STEP   (STEP)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .load     (load[c]),
      .snap     (snap),
      .val_int  (val_int),
      .val_frac (val_frac),
      .len_int  (len_int[c*INT_W +: INT_W]),
      .len_frac (len_frac[c*FRAC_W +: FRAC_W]),
      .busy     (busy[c]),
      .done     (done[c])
    );
  end

endmodule

// File: tb/tb_lightsaber_length_ctrl.sv
// Bench for lightsaber_length_ctrl: hundredths-based model
// feeding a scoreboard, plus a command table and corner cases.
module tb_lightsaber_length_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [0:0]  cmd_ch = '0;
  logic [1:0]  cmd_op = '0;
  logic [1:0]  cmd_int = '0;
  logic [6:0]  cmd_frac = '0;
  logic        cmd_err;
  logic [3:0]  len_int;
  logic [13:0] len_frac;
  logic [1:0]  busy;
  logic [1:0]  done;

  localparam logic [1:0] SET = 2'b00;
  localparam logic [1:0] EXT = 2'b01;
  localparam logic [1:0] RET = 2'b10;
  localparam logic [1:0] SNP = 2'b11;

  lightsaber_length_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ch    (cmd_ch),
    .cmd_op    (cmd_op),
    .cmd_int   (cmd_int),
    .cmd_frac  (cmd_frac),
    .cmd_err   (cmd_err),
    .len_int   (len_int),
    .len_frac  (len_frac),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  li;
    logic [13:0] lf;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic        err;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    int         ch;
    int         i;
    int         f;
    logic       err;
  } vec_t;

  exp_t sb[$];
  int   m_len[2];
  int   m_tgt[2];
  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ln(input int c);
    return (len_int[c*2 +: 2] * 100) + len_frac[c*7 +: 7];
  endfunction

  task automatic cyc(input logic t, input logic v, input int ch,
                     input logic [1:0] op, input int i, input int f);
    exp_t e;
    int   val;
    logic err;
    logic dn;
    tick      = t;
    cmd_valid = v;
    cmd_ch    = ch[0:0];
    cmd_op    = op;
    cmd_int   = i[1:0];
    cmd_frac  = f[6:0];
    val = (op == EXT) ? 300 : (op == RET) ? 0 : i * 100 + f;
    err = v && (op == SET || op == SNP) && (f > 99 || val > 300);
    e.err = err;
    for (int c = 0; c < 2; c++) begin
      dn = 1'b0;
      if (v && !err && ch == c) begin
        m_tgt[c] = val;
        if (op == SNP) m_len[c] = val;
      end else if (t && m_len[c] != m_tgt[c]) begin
        if (m_len[c] < m_tgt[c])
          m_len[c] = (m_len[c] + 5 > m_tgt[c]) ? m_tgt[c] : m_len[c] + 5;
        else
          m_len[c] = (m_len[c] - 5 < m_tgt[c]) ? m_tgt[c] : m_len[c] - 5;
        dn = (m_len[c] == m_tgt[c]);
      end
      e.li[c*2 +: 2]  = 2'(m_len[c] / 100);
      e.lf[c*7 +: 7]  = 7'(m_len[c] % 100);
      e.busy[c]       = (m_len[c] != m_tgt[c]);
      e.done[c]       = dn;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_len_int", len_int, e.li);
    chk("sb_len_frac", len_frac, e.lf);
    chk("sb_busy", busy, e.busy);
    chk("sb_done", done, e.done);
    chk("sb_cmd_err", cmd_err, e.err);
    chk("sb_cmd_ready", cmd_ready, 1);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_len_int"}, len_int, 0);
    chk({name, "_len_frac"}, len_frac, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_cmd_err"}, cmd_err, 0);
    chk({name, "_cmd_ready"}, cmd_ready, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{SET, 0, 0, 100, 1'b1};
    tbl[1] = '{SET, 0, 3, 1,   1'b1};
    tbl[2] = '{SNP, 1, 3, 50,  1'b1};
    tbl[3] = '{SNP, 1, 1, 120, 1'b1};
    tbl[4] = '{SNP, 1, 3, 0,   1'b0};
    tbl[5] = '{SET, 1, 2, 99,  1'b0};
    for (int c = 0; c < 2; c++) begin
      m_len[c] = 0;
      m_tgt[c] = 0;
    end

    #12;
    chk_zero("in_reset");
    rst_n = 1'b1;
    cyc(0, 0, 0, SET, 0, 0);

    cyc(1, 1, 0, EXT, 0, 0);
    chk("ext_cmd_no_step", ln(0), 0);
    for (int k = 1; k <= 60; k++) begin
      cyc(1, 0, 0, SET, 0, 0);
      if (k == 19) chk("ext_0.95", ln(0), 95);
      if (k == 20) chk("ext_1.00", ln(0), 100);
      if (k == 60) begin
        chk("ext_3.00", ln(0), 300);
        chk("ext_done", done[0], 1);
        chk("ext_busy_low", busy[0], 0);
      end
    end
    cyc(1, 0, 0, SET, 0, 0);
    chk("ext_done_single", done[0], 0);

    cyc(0, 1, 1, SNP, 2, 3);
    chk("snap_2.03", ln(1), 203);
    chk("snap_no_done", done[1], 0);
    chk("snap_not_busy", busy[1], 0);
    cyc(1, 1, 1, RET, 0, 0);
    chk("ret_cmd_hold", ln(1), 203);
    for (int k = 1; k <= 41; k++) begin
      cyc(1, 0, 0, SET, 0, 0);
      if (k == 1) chk("ret_borrow_1.98", ln(1), 198);
      if (k == 41) begin
        chk("ret_0.00", ln(1), 0);
        chk("ret_done", done[1], 1);
      end
    end

    cyc(0, 1, 0, SNP, 0, 0);
    cyc(1, 1, 0, SET, 0, 99);
    for (int k = 1; k <= 20; k++) begin
      cyc(1, 0, 0, SET, 0, 0);
      if (k == 19) chk("set_0.95", ln(0), 95);
      if (k == 20) begin
        chk("set_clamp_0.99", ln(0), 99);
        chk("set_done", done[0], 1);
      end
    end

    for (int k = 0; k < 6; k++) begin
      cyc(0, 1, tbl[k].ch, tbl[k].op, tbl[k].i, tbl[k].f);
      chk($sformatf("tbl%0d_cmd_err", k), cmd_err, tbl[k].err);
    end
    chk("tbl_ch0_kept", ln(0), 99);
    chk("tbl_ch1_busy", busy[1], 1);
    cyc(1, 0, 0, SET, 0, 0);
    chk("ret_clamp_2.99", ln(1), 299);
    chk("ret_clamp_done", done[1], 1);

    cyc(0, 1, 0, SNP, 0, 0);
    cyc(0, 1, 1, SNP, 0, 0);
    cyc(1, 1, 0, EXT, 0, 0);
    for (int k = 1; k <= 30; k++)
      cyc(1, k == 25, 1, EXT, 0, 0);
    chk("mid_1.50", ln(0), 150);
    cyc(1, 1, 0, RET, 0, 0);
    chk("retgt_hold_1.50", ln(0), 150);
    chk("retgt_no_done", done[0], 0);
    chk("other_ch_stepped", ln(1), 30);
    cyc(1, 0, 0, SET, 0, 0);
    chk("retgt_1.45", ln(0), 145);
    for (int k = 0; k < 3; k++)
      cyc(0, 0, 0, SET, 0, 0);
    chk("freeze_1.45", ln(0), 145);
    cyc(1, 0, 0, SET, 0, 0);

    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    for (int c = 0; c < 2; c++) begin
      m_len[c] = 0;
      m_tgt[c] = 0;
    end
    #2;
    rst_n = 1'b1;
    cyc(1, 0, 0, SET, 0, 0);
    cyc(1, 1, 0, EXT, 0, 0);
    cyc(1, 0, 0, SET, 0, 0);
    chk("post_rst_0.05", ln(0), 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
